// File: rtl/dbg_bus_arbiter.sv
// Shares the SoC memory bus between the debug loader and the CPU, debug first.
// Define DBG_ARB_CPU_HOLD_EN to hold the CPU in reset during and after a debug session.
module dbg_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_mem_op,
  input  logic [3:0]        dbg_wren,
  input  logic [ADDR_W-1:0] dbg_adr,
  input  logic [31:0]       dbg_do,
  output logic [31:0]       dbg_di,
  output logic              dbg_ack,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_wren,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic [3:0]        mem_wren,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              cpu_n_reset,
  output logic              dbg_active
);

  typedef enum logic [1:0] {S_IDLE, S_DBG, S_CPU} state_t;

  state_t              r_state, w_state_nxt;
  logic                w_grant_dbg, w_grant_cpu, w_dbg_pend, w_cpu_ok;
  logic                r_mem_req, r_dbg_ack, r_cpu_ack, r_armed;
  logic [3:0]          r_mem_wren, r_cap_wren;
  logic [ADDR_W-1:0]   r_mem_adr, r_cap_adr;
  logic [31:0]         r_mem_wdata, r_dbg_di, r_cpu_rdata, r_cap_do;
  logic                r_cpu_n_reset, r_dbg_active;

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_hold_range
    $error("dbg_bus_arbiter: HOLD_CYCLES must be 1..65535");
  end

  // r_armed covers the first cycle(s) after a 0->1 edge until that op is granted,
  // so an edge seen while the CPU owns the bus is not lost.
  assign w_dbg_pend = dbg_mem_op &
                      (r_armed | (dbg_adr != r_cap_adr) | (dbg_wren != r_cap_wren) |
                       (dbg_do != r_cap_do));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_dbg = 1'b0;
    w_grant_cpu = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_dbg_pend) begin
          w_state_nxt = S_DBG;
          w_grant_dbg = 1'b1;
        end else if (cpu_req && w_cpu_ok) begin
          w_state_nxt = S_CPU;
          w_grant_cpu = 1'b1;
        end
      end
      S_DBG, S_CPU: if (mem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req   <= 1'b0;
      r_mem_wren  <= '0;
      r_mem_adr   <= '0;
      r_mem_wdata <= '0;
      r_dbg_di    <= '0;
      r_dbg_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_cap_adr   <= '0;
      r_cap_wren  <= '0;
      r_cap_do    <= '0;
      r_armed     <= 1'b1;
    end else begin
      r_dbg_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      if (!dbg_mem_op) r_armed <= 1'b1;
      if (w_grant_dbg) begin
        r_mem_req   <= 1'b1;
        r_mem_wren  <= dbg_wren;
        r_mem_adr   <= dbg_adr;
        r_mem_wdata <= dbg_do;
        r_cap_wren  <= dbg_wren;
        r_cap_adr   <= dbg_adr;
        r_cap_do    <= dbg_do;
        r_armed     <= 1'b0;
      end else if (w_grant_cpu) begin
        r_mem_req   <= 1'b1;
        r_mem_wren  <= cpu_wren;
        r_mem_adr   <= cpu_adr;
        r_mem_wdata <= cpu_wdata;
      end else if (r_state != S_IDLE && mem_ack) begin
        r_mem_req <= 1'b0;
        if (r_state == S_DBG) begin
          r_dbg_di  <= mem_rdata;
          r_dbg_ack <= 1'b1;
        end else begin
          r_cpu_rdata <= mem_rdata;
          r_cpu_ack   <= 1'b1;
        end
      end
    end
  end

`ifdef DBG_ARB_CPU_HOLD_EN
  logic        r_sess, r_hold_run;
  logic [15:0] r_hold_cnt;

  // Countdown is loaded when the session ends (after any in-flight debug op),
  // then cpu_n_reset releases on the edge after the counter has reached zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sess        <= 1'b0;
      r_hold_run    <= 1'b0;
      r_hold_cnt    <= '0;
      r_cpu_n_reset <= 1'b0;
      r_dbg_active  <= 1'b0;
    end else if (dbg_mem_op) begin
      r_sess        <= 1'b1;
      r_hold_run    <= 1'b0;
      r_hold_cnt    <= '0;
      r_cpu_n_reset <= 1'b0;
      r_dbg_active  <= 1'b1;
    end else if (r_sess && r_state != S_DBG) begin
      r_sess       <= 1'b0;
      r_hold_run   <= 1'b1;
      r_hold_cnt   <= 16'(HOLD_CYCLES);
      r_dbg_active <= 1'b1;
    end else if (r_hold_run) begin
      if (r_hold_cnt == 16'd0) begin
        r_hold_run    <= 1'b0;
        r_cpu_n_reset <= 1'b1;
        r_dbg_active  <= 1'b0;
      end else begin
        r_hold_cnt <= r_hold_cnt - 16'd1;
      end
    end else if (!r_sess) begin
      r_cpu_n_reset <= 1'b1;
      r_dbg_active  <= 1'b0;
    end
  end

  assign w_cpu_ok = r_cpu_n_reset;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_n_reset <= 1'b0;
      r_dbg_active  <= 1'b0;
    end else begin
      r_cpu_n_reset <= 1'b1;
      r_dbg_active  <= dbg_mem_op;
    end
  end

  assign w_cpu_ok = 1'b1;
`endif

  assign mem_req     = r_mem_req;
  assign mem_wren    = r_mem_wren;
  assign mem_adr     = r_mem_adr;
  assign mem_wdata   = r_mem_wdata;
  assign dbg_di      = r_dbg_di;
  assign dbg_ack     = r_dbg_ack;
  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_ack     = r_cpu_ack;
  assign cpu_n_reset = r_cpu_n_reset;
  assign dbg_active  = r_dbg_active;

endmodule

// File: tb/tb_dbg_bus_arbiter.sv
// Directed bench for dbg_bus_arbiter: vector table for debug loading plus
// hand-written sequences for hold release, collision, simultaneous requests and mid-op reset.
module tb_dbg_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset, dbg_mem_op, dbg_ack, cpu_req, cpu_ack, mem_req, mem_ack;
  logic        cpu_n_reset, dbg_active;
  logic [3:0]  dbg_wren, cpu_wren, mem_wren;
  logic [31:0] dbg_adr, dbg_do, dbg_di, cpu_adr, cpu_wdata, cpu_rdata;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        zw, ack_man;

  int n_vec = 0, n_bad = 0;
  int n_mem = 0, n_dack = 0, n_cack = 0;
  logic [31:0] l_adr, l_wdata;
  logic [3:0]  l_wren;

  always #5 clk = ~clk;

  assign mem_ack = mem_req & (zw | ack_man);

  dbg_bus_arbiter #(.ADDR_W(32), .HOLD_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .dbg_mem_op(dbg_mem_op), .dbg_wren(dbg_wren), .dbg_adr(dbg_adr), .dbg_do(dbg_do),
    .dbg_di(dbg_di), .dbg_ack(dbg_ack),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_req(mem_req), .mem_wren(mem_wren), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .cpu_n_reset(cpu_n_reset), .dbg_active(dbg_active)
  );

  // bus monitor: logs completed memory transactions and ack pulses
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_req && mem_ack) begin
        n_mem   = n_mem + 1;
        l_adr   = mem_adr;
        l_wren  = mem_wren;
        l_wdata = mem_wdata;
      end
      if (dbg_ack) n_dack = n_dack + 1;
      if (cpu_ack) n_cack = n_cack + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  wren;
    logic [31:0] wdo;
    logic [31:0] rdata;
    int          cyc;
    logic        exp_new;
  } vec_t;

  vec_t vt[6];

`ifdef DBG_ARB_CPU_HOLD_EN
  localparam logic SESS_NRST = 1'b0;
`else
  localparam logic SESS_NRST = 1'b1;
`endif

  initial begin
    int  b_mem, b_d, b_c;
    logic got;

    vt[0] = '{32'h0002_0000, 4'hF, 32'h0000_006F, 32'h0, 50, 1'b1};
    vt[1] = '{32'h0002_0000, 4'hF, 32'h0000_006F, 32'h0,  6, 1'b0};
    vt[2] = '{32'h0002_0004, 4'hF, 32'h0000_0001, 32'h0,  6, 1'b1};
    vt[3] = '{32'h0002_0008, 4'hF, 32'h0000_0002, 32'h0,  6, 1'b1};
    vt[4] = '{32'h0002_0008, 4'h0, 32'h0000_0002, 32'hDEAD_BEEF, 6, 1'b1};
    vt[5] = '{32'h0002_0008, 4'h0, 32'h0000_0002, 32'hDEAD_BEEF, 6, 1'b0};

    reset = 1'b1; dbg_mem_op = 1'b0; dbg_wren = '0; dbg_adr = '0; dbg_do = '0;
    cpu_req = 1'b0; cpu_wren = '0; cpu_adr = '0; cpu_wdata = '0;
    mem_rdata = '0; zw = 1'b1; ack_man = 1'b0;

    // reset state
    step(); step();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_cpu_n_reset", {31'b0, cpu_n_reset}, 32'd0);
    chk("rst_dbg_active", {31'b0, dbg_active}, 32'd0);
    chk("rst_acks", {30'b0, dbg_ack, cpu_ack}, 32'd0);
    chk("rst_mem_adr", mem_adr, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_cpu_n_reset", {31'b0, cpu_n_reset}, 32'd1);

    // debug load vectors, dbg_mem_op held high throughout
    for (int i = 0; i < 6; i++) begin
      dbg_mem_op = 1'b1;
      dbg_adr = vt[i].adr; dbg_wren = vt[i].wren; dbg_do = vt[i].wdo;
      mem_rdata = vt[i].rdata;
      b_mem = n_mem; b_d = n_dack;
      repeat (vt[i].cyc) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_txn_cnt", i), n_mem - b_mem, {31'b0, vt[i].exp_new});
      chk($sformatf("v%0d_dbg_ack_cnt", i), n_dack - b_d, {31'b0, vt[i].exp_new});
      if (vt[i].exp_new) begin
        chk($sformatf("v%0d_mem_adr", i), l_adr, vt[i].adr);
        chk($sformatf("v%0d_mem_wren", i), {28'b0, l_wren}, {28'b0, vt[i].wren});
        chk($sformatf("v%0d_mem_wdata", i), l_wdata, vt[i].wdo);
        if (vt[i].wren == 4'h0) chk($sformatf("v%0d_dbg_di", i), dbg_di, vt[i].rdata);
      end
      chk($sformatf("v%0d_cpu_n_reset", i), {31'b0, cpu_n_reset}, {31'b0, SESS_NRST});
      chk($sformatf("v%0d_dbg_active", i), {31'b0, dbg_active}, 32'd1);
    end
    chk("load_total_txns", n_mem, 32'd4);

    // hold release
    dbg_mem_op = 1'b0;
`ifdef DBG_ARB_CPU_HOLD_EN
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i == 17) begin
        chk("hold_nrst_at_16", {31'b0, cpu_n_reset}, 32'd0);
        chk("hold_active_at_16", {31'b0, dbg_active}, 32'd1);
      end
      if (i == 18) begin
        chk("hold_nrst_at_17", {31'b0, cpu_n_reset}, 32'd1);
        chk("hold_active_at_17", {31'b0, dbg_active}, 32'd0);
      end
    end
`else
    step(); step();
    chk("nohold_nrst", {31'b0, cpu_n_reset}, 32'd1);
    chk("nohold_active", {31'b0, dbg_active}, 32'd0);
`endif

    // first CPU read after release
    cpu_req = 1'b1; cpu_adr = 32'h0002_0000; cpu_wren = 4'h0; mem_rdata = 32'h0000_006F;
    b_c = n_cack; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      got = cpu_ack;
    end
    cpu_req = 1'b0;
    chk("cpu_rd_ack_seen", {31'b0, got}, 32'd1);
    chk("cpu_rd_rdata", cpu_rdata, 32'h0000_006F);
    chk("cpu_rd_mem_adr", l_adr, 32'h0002_0000);
    step();
    chk("cpu_ack_one_cycle", {31'b0, cpu_ack}, 32'd0);
    chk("cpu_ack_cnt", n_cack - b_c, 32'd1);

    // collision: CPU read in flight, mem_ack delayed, debug rises mid-op
    zw = 1'b0; ack_man = 1'b0;
    cpu_req = 1'b1; cpu_adr = 32'h0003_0000; cpu_wren = 4'h0; mem_rdata = 32'h0000_1234;
    step();
    chk("col_cpu_mem_req", {31'b0, mem_req}, 32'd1);
    chk("col_cpu_mem_adr", mem_adr, 32'h0003_0000);
    step(); step();
    dbg_mem_op = 1'b1; dbg_adr = 32'h0002_0010; dbg_wren = 4'hF; dbg_do = 32'h0000_0055;
    step();
    chk("col_hold_adr", mem_adr, 32'h0003_0000);
    chk("col_no_preempt", {30'b0, mem_req, dbg_ack}, 32'd2);
    step();
    ack_man = 1'b1;
    step();
    chk("col_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    chk("col_cpu_rdata", cpu_rdata, 32'h0000_1234);
    chk("col_req_drop", {31'b0, mem_req}, 32'd0);
    cpu_req = 1'b0; ack_man = 1'b0; zw = 1'b1;
    step();
    chk("col_dbg_grant_req", {31'b0, mem_req}, 32'd1);
    chk("col_dbg_grant_adr", mem_adr, 32'h0002_0010);
    chk("col_dbg_grant_data", mem_wdata, 32'h0000_0055);
    step();
    chk("col_dbg_ack", {31'b0, dbg_ack}, 32'd1);

    // simultaneous CPU request and new debug op
    cpu_req = 1'b1; cpu_adr = 32'h0003_0004; cpu_wren = 4'h0; mem_rdata = 32'h0000_CAFE;
    dbg_adr = 32'h0002_0014;
    step();
    chk("sim_dbg_first", mem_adr, 32'h0002_0014);
    step();
    chk("sim_dbg_ack", {31'b0, dbg_ack}, 32'd1);
    chk("sim_req_gap", {31'b0, mem_req}, 32'd0);
    step();
    chk("sim_cpu_grant", {31'b0, mem_req}, {31'b0, SESS_NRST});
    step();
    chk("sim_cpu_ack", {31'b0, cpu_ack}, {31'b0, SESS_NRST});
`ifndef DBG_ARB_CPU_HOLD_EN
    chk("sim_cpu_rdata", cpu_rdata, 32'h0000_CAFE);
`endif
    cpu_req = 1'b0;
    step();

    // reset while a debug op is outstanding
    zw = 1'b0; ack_man = 1'b0; dbg_adr = 32'h0002_0018;
    step();
    chk("mid_req_up", {31'b0, mem_req}, 32'd1);
    chk("mid_adr", mem_adr, 32'h0002_0018);
    reset = 1'b1; ack_man = 1'b1;
    step();
    chk("mid_rst_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_adr", mem_adr, 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    chk("mid_rst_wren", {28'b0, mem_wren}, 32'd0);
    chk("mid_rst_dbg_di", dbg_di, 32'd0);
    chk("mid_rst_acks", {30'b0, dbg_ack, cpu_ack}, 32'd0);
    chk("mid_rst_nrst", {31'b0, cpu_n_reset}, 32'd0);
    chk("mid_rst_active", {31'b0, dbg_active}, 32'd0);
    dbg_mem_op = 1'b0; ack_man = 1'b0;
    step();
    chk("mid_rst_no_ack", {31'b0, dbg_ack}, 32'd0);
    reset = 1'b0;
    step();
    chk("mid_post_nrst", {31'b0, cpu_n_reset}, 32'd1);
    chk("mid_post_req", {31'b0, mem_req}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
